// File: rtl/tagger_channel_arbiter.sv
// tagger_channel_arbiter
// Timestamps per-channel edge events with a free-running coarse counter,
// parks each one in a one-deep slot per channel, and serializes the slots
// round-robin onto a single valid/ready tag stream. Dropped events are
// counted in a saturating lost counter.
// Optional feature macro: TAGGER_ROLLOVER_MARKER_EN. When it is defined, a
// marker tag is emitted on every coarse counter wrap.
module tagger_channel_arbiter #(
    parameter int CHANNELS     = 4,
    parameter int BITS         = 3,
    parameter int COARSE_WIDTH = 24
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic [CHANNELS-1:0]                edge_valid,
    input  logic [CHANNELS*BITS-1:0]           subtimes,
    output logic                               tag_valid,
    input  logic                               tag_ready,
    output logic [$clog2(CHANNELS)-1:0]        tag_channel,
    output logic                               tag_marker,
    output logic [COARSE_WIDTH+BITS-1:0]       tag_time,
    output logic [15:0]                        lost_count
);

    localparam int CW = $clog2(CHANNELS);
    localparam int TW = COARSE_WIDTH + BITS;

    logic [COARSE_WIDTH-1:0]        cnt_q, cnt_d;
    logic [CHANNELS-1:0]            pend_q, pend_d;
    logic [CHANNELS-1:0][TW-1:0]    slot_q, slot_d;
    logic                           tag_valid_q, tag_valid_d;
    logic [CW-1:0]                  tag_channel_q, tag_channel_d;
    logic [TW-1:0]                  tag_time_q, tag_time_d;
    logic [CW-1:0]                  last_grant_q, last_grant_d;
    logic [15:0]                    lost_q, lost_d;

    logic                           out_free;
    logic                           ch_found;
    logic [CW-1:0]                  ch_idx;
    logic                           ch_gnt;
    logic                           mk_gnt;
    logic                           marker_req;

`ifdef TAGGER_ROLLOVER_MARKER_EN
    logic                           marker_q, marker_d;
    logic                           tag_marker_q, tag_marker_d;
    assign marker_req = marker_q;
    assign tag_marker = tag_marker_q;
`else
    assign marker_req = 1'b0;
    assign tag_marker = 1'b0;
`endif

    // Grant selection: marker first, then first pending channel after last_grant.
    always_comb begin
        int idx;
        idx      = 0;
        out_free = !tag_valid_q || tag_ready;
        ch_found = 1'b0;
        ch_idx   = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = (int'(last_grant_q) + k) % CHANNELS;
            if (!ch_found && pend_q[idx]) begin
                ch_found = 1'b1;
                ch_idx   = CW'(idx);
            end
        end
        mk_gnt = out_free && marker_req;
        ch_gnt = out_free && ch_found && !marker_req;
    end

    // Next-state: counter, slot capture/drop, marker flag, output register, lost count.
    always_comb begin
        logic        freed;
        logic [4:0]  drops;
        logic [16:0] sum;
        freed         = 1'b0;
        drops         = '0;
        sum           = '0;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        slot_d        = slot_q;
        tag_valid_d   = tag_valid_q;
        tag_channel_d = tag_channel_q;
        tag_time_d    = tag_time_q;
        last_grant_d  = last_grant_q;
`ifdef TAGGER_ROLLOVER_MARKER_EN
        marker_d      = marker_q;
        tag_marker_d  = tag_marker_q;
`endif

        if (enable) cnt_d = cnt_q + COARSE_WIDTH'(1);

        // A slot freed this cycle can take a new edge in the same cycle.
        for (int i = 0; i < CHANNELS; i++) begin
            freed = ch_gnt && (ch_idx == CW'(i));
            if (freed) pend_d[i] = 1'b0;
            if (enable && edge_valid[i]) begin
                if (pend_q[i] && !freed) begin
                    drops = drops + 5'd1;
                end else begin
                    pend_d[i] = 1'b1;
                    slot_d[i] = {cnt_q, subtimes[i*BITS +: BITS]};
                end
            end
        end

`ifdef TAGGER_ROLLOVER_MARKER_EN
        if (mk_gnt) marker_d = 1'b0;
        if (enable && (&cnt_q)) begin
            if (marker_q && !mk_gnt) drops = drops + 5'd1;
            marker_d = 1'b1;
        end
`endif

        if (out_free) begin
            tag_valid_d = mk_gnt || ch_gnt;
            if (mk_gnt) begin
                tag_channel_d = '0;
                tag_time_d    = '0;
`ifdef TAGGER_ROLLOVER_MARKER_EN
                tag_marker_d  = 1'b1;
`endif
            end else if (ch_gnt) begin
                tag_channel_d = ch_idx;
                tag_time_d    = slot_q[ch_idx];
                last_grant_d  = ch_idx;
`ifdef TAGGER_ROLLOVER_MARKER_EN
                tag_marker_d  = 1'b0;
`endif
            end
        end

        sum    = {1'b0, lost_q} + 17'(drops);
        lost_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            pend_q        <= '0;
            slot_q        <= '0;
            tag_valid_q   <= 1'b0;
            tag_channel_q <= '0;
            tag_time_q    <= '0;
            last_grant_q  <= CW'(CHANNELS - 1);
            lost_q        <= '0;
`ifdef TAGGER_ROLLOVER_MARKER_EN
            marker_q      <= 1'b0;
            tag_marker_q  <= 1'b0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            slot_q        <= slot_d;
            tag_valid_q   <= tag_valid_d;
            tag_channel_q <= tag_channel_d;
            tag_time_q    <= tag_time_d;
            last_grant_q  <= last_grant_d;
            lost_q        <= lost_d;
`ifdef TAGGER_ROLLOVER_MARKER_EN
            marker_q      <= marker_d;
            tag_marker_q  <= tag_marker_d;
`endif
        end
    end

    assign tag_valid   = tag_valid_q;
    assign tag_channel = tag_channel_q;
    assign tag_time    = tag_time_q;
    assign lost_count  = lost_q;

endmodule

// File: doc/tagger_channel_arbiter.md
# tagger_channel_arbiter

- Collects edge events from `CHANNELS` per-channel BCD converters, each event being `edge_detected` plus `subtimes`.
- Stamps each event with a free-running coarse cycle counter and buffers it in a one-deep pending slot per channel.
- A round-robin scheduler serializes the slots onto a single valid/ready tag stream for the downstream FIFO/USB packer.
- Sits between the converter bank and the readout path; owns the coarse time base and the lost-event accounting.

## Interface
Parameters:
- `CHANNELS`, 4 — number of converter inputs (2..16).
- `BITS`, 3 — subtime width per channel (the converter's `BITS`).
- `COARSE_WIDTH`, 24 — coarse counter width.

Ports:
- `clk` input 1 — single clock, all logic rising-edge.
- `rst_n` input 1 — synchronous, active-low reset.
- `enable` input 1 — run gate for the counter and event capture.
- `edge_valid` input CHANNELS — bit i is `edge_detected` of converter i.
- `subtimes` input CHANNELS*BITS — channel i occupies bits [i*BITS +: BITS].
- `tag_valid` output 1 — output tag present.
- `tag_ready` input 1 — downstream accepts.
- `tag_channel` output $clog2(CHANNELS) — source channel.
- `tag_marker` output 1 — tag is a rollover marker.
- `tag_time` output COARSE_WIDTH+BITS — {coarse, subtime}.
- `lost_count` output 16 — saturating count of dropped events.

## Operation
- Coarse counter increments every cycle `enable`=1 and holds when `enable`=0. It wraps modulo 2^COARSE_WIDTH.
- Capture:
  - With `enable`=1 and `edge_valid[i]`=1, slot i loads {counter value this cycle, subtimes[i]} and sets `pend[i]`.
  - If `pend[i]` is already set and not freed this cycle, the event is dropped and `lost_count` increments (saturates at 0xFFFF).
  - With `enable`=0, all edges are ignored and not counted. Pending slots still drain.
- Simultaneous events: in one cycle, each dropped channel and a dropped marker each count 1 toward `lost_count`.
- Output register:
  - It is "free" when `tag_valid`=0, or when `tag_valid`&`tag_ready`=1 this cycle.
  - When free and any request is pending, it loads the granted request the same edge and clears that slot.
- Grant priority:
  - A pending rollover marker wins first (only with the macro).
  - Otherwise round-robin: the lowest-index pending channel strictly above `last_grant`, wrapping to 0.
  - `last_grant` updates only on a channel grant. Its reset value is CHANNELS-1, so channel 0 is first.
- Slot freed and new edge on the same channel in the same cycle: the new edge is captured, `pend` stays 1, and nothing is lost.
- Handshake: once `tag_valid`=1, `tag_channel`, `tag_marker` and `tag_time` hold stable until a transfer (`tag_valid`&`tag_ready`). `tag_valid` never drops without a transfer except on reset.
- Reset (`rst_n`=0 at an edge):
  - Counter, `pend`, the marker flag, `tag_valid`, `tag_channel`, `tag_marker`, `tag_time` and `lost_count` all go to 0.
  - `last_grant` goes to CHANNELS-1.
  - A reset mid-transfer discards the tag.

## Timing
- `edge_valid` at cycle t → slot loaded at the end of t → `tag_valid`=1 from cycle t+2 if the output register is free at t+1. Minimum latency is 2 cycles.
- Sustained throughput is 1 tag/cycle with `tag_ready` held high.
- `tag_time` coarse field is the counter value during cycle t. Converter pipeline latency is compensated downstream.
- `lost_count` updates the cycle after the dropping edge.

## Configuration
- `TAGGER_ROLLOVER_MARKER_EN` defined:
  - When the counter steps from all-ones to 0 (`enable`=1), a marker flag is set.
  - The marker is emitted with `tag_marker`=1, `tag_channel`=0, `tag_time`=0, at priority above all channels.
  - If the flag is still set at the next wrap, `lost_count` increments.
- Undefined:
  - No marker logic; `tag_marker` is tied 0 and the counter wraps silently.

## Test plan
- Reset, `enable`=1, edge on ch2 with subtime 5 at counter 10, `tag_ready`=1 → tag at t+2: channel 2, `tag_time`={10,5}, marker 0. One `tag_valid` pulse only.
- Edges on ch0..ch3 in the same cycle (counter 20) → four consecutive tags in order ch0, ch1, ch2, ch3, all coarse 20, `lost_count`=0.
- `tag_ready`=0 for 5 cycles with ch1 edges on 3 consecutive cycles → the first is held stable on output, the second sits pending, the third is dropped. `lost_count`=1; after `tag_ready`=1 the tags out are the first and second.
- Edge on ch1 in the same cycle its slot is granted → both events emerge, `lost_count` stays 0.
- `COARSE_WIDTH`=4 with the macro defined, run 16 cycles → marker tag (`tag_marker`=1, `tag_time`=0) after the 15→0 wrap, ahead of a simultaneous ch3 edge. Without the macro, no marker appears.
- `rst_n`=0 while `tag_valid`=1 and two slots are pending → next cycle all outputs are 0. Nothing is emitted from the old pending slots after release.
